sram_ctrl_1rw1r: RTL and testbench
==================================

Name: sram_ctrl_1rw1r

Overview:
- Initiator-side controller for the 1RW+1R 32x256 byte-masked SRAM macro.
- Converts two core-facing request/grant/rvalid ports into macro pin activity: data port (RW, macro port 0) and instruction port (R-only, macro port 1).
- Adds post-reset zero-fill, address range checking and write/read same-address hazard stalling.
- Sits between the core's LSU/fetch unit and the macro instance.

Parameters:
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 8, macro word-address width (depth = 1<<ADDR_WIDTH)
- NUM_WMASKS, 4, byte enables per word
- BASE_ADDR, 32'h0000_0000, byte base address of the SRAM window
- INIT_ZERO, 1, 1 = zero-fill all words after reset before granting any request

Ports:
- clk_i  in  1  clock; also drives macro clk0/clk1 at top level
- rst_ni  in  1  reset, asynchronous, active-low
- d_req_i  in  1  data request
- d_gnt_o  out  1  data grant (request accepted this cycle)
- d_we_i  in  1  1 = write
- d_be_i  in  4  byte enables
- d_addr_i  in  32  byte address
- d_wdata_i  in  32  write data
- d_rvalid_o  out  1  data response valid
- d_rdata_o  out  32  read data
- d_err_o  out  1  response error (out of range)
- i_req_i  in  1  instruction request
- i_gnt_o  out  1  instruction grant
- i_addr_i  in  32  byte address
- i_rvalid_o  out  1  instruction response valid
- i_rdata_o  out  32  instruction word
- i_err_o  out  1  instruction response error
- init_done_o  out  1  zero-fill complete
- csb0_o  out  1  macro port 0 chip select, active-low
- web0_o  out  1  macro port 0 write enable, active-low
- wmask0_o  out  4  macro byte mask
- addr0_o  out  8  macro port 0 word address
- din0_o  out  32  macro write data
- dout0_i  in  32  macro port 0 read data
- csb1_o  out  1  macro port 1 chip select, active-low
- addr1_o  out  8  macro port 1 word address
- dout1_i  in  32  macro port 1 read data

Behaviour:
- Reset values:
  - csb0_o=1, csb1_o=1, web0_o=1, wmask0_o=0, addr0_o/addr1_o/din0_o=0.
  - All gnt/rvalid/err outputs 0; init_done_o = !INIT_ZERO.
  - FSM = INIT if INIT_ZERO, else RUN; fill counter = 0.
- Macro pins are driven combinationally from accepted requests. The macro registers them at the posedge that ends the grant cycle.
- FSM INIT:
  - Each cycle: csb0=0, web0=0, wmask0=4'hF, din0=0, addr0=counter; counter++.
  - After the word at counter==RAM_DEPTH-1 is written: go to RUN, init_done_o=1 the next cycle.
  - gnt outputs stay 0 throughout INIT.
- FSM RUN:
  - In range: (addr - BASE_ADDR) < 4*RAM_DEPTH. Word index = offset[ADDR_WIDTH+1:2]; addr[1:0] is ignored.
  - Data port:
    - d_gnt_o = d_req_i (no stall source).
    - An in-range grant drives csb0=0, web0=!d_we_i, wmask0=d_we_i ? d_be_i : 0, din0=d_wdata_i.
    - An out-of-range grant leaves csb0=1.
  - Instruction port:
    - i_gnt_o = i_req_i && !hazard.
    - hazard = d_req_i && d_we_i && data in range && instr in range && equal word indices.
    - A granted in-range instruction request drives csb1=0, addr1=index.
- Latency: fixed 1 cycle.
  - rvalid asserts the cycle after gnt, for reads, writes and errors alike.
  - err is registered alongside rvalid.
  - Back-to-back grants every cycle are legal; at most one response per port is outstanding.
- Response data:
  - d_rdata_o = dout0_i when d_rvalid_o && read && !err, else 0.
  - i_rdata_o = dout1_i when i_rvalid_o && !err, else 0.
  - Write responses return rdata 0.
- Simultaneous data write and instruction read of different words: both granted the same cycle.
- Same word: instruction stalled exactly one cycle. The next cycle returns the newly written data.
- Reset mid-operation (INIT or RUN): asynchronous return to reset values, pending responses discarded, zero-fill restarts from word 0.

Decomposition:
- Package sram_ctrl_pkg:
  - state enum {INIT, RUN}
  - SRAM geometry localparams
  - in-range/word-index helper function
- Sub-module sram_ctrl_rsp_tracker: one instance per port. 1-deep response register holding valid, err and is_read.

Test Plan:
- Reset with INIT_ZERO=1 -> gnt=0 for 256 cycles, csb0 low with addr0 0..255; init_done_o=1 on cycle 257; read of word 0x10 returns 0.
- Data write addr 0x40, be=4'b0101, wdata=0xAABBCCDD, then read 0x40 -> rdata 0x00BB00DD one cycle after the read grant.
- Data write and instruction read both at 0x80 in the same cycle -> i_gnt_o=0 for one cycle; instruction rvalid two cycles later with the written value.
- Data read 0x400 (out of range, default depth) -> csb0 stays 1; next cycle d_rvalid=1, d_err=1, d_rdata=0.
- Back-to-back instruction reads 0x0, 0x4, 0x8 with req held high -> three consecutive rvalid cycles, data in order.
- rst_ni asserted mid-INIT at counter=100 -> csb0_o=1 immediately; after release, fill restarts at addr0=0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types, geometry defaults and address helpers for the 1RW+1R SRAM controller.
package sram_ctrl_pkg;

    // Controller phases: zero-fill after reset, then normal request service.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Default macro geometry (32 bits x 256 words, byte-masked).
    localparam int unsigned SRAM_DATA_WIDTH = 32;
    localparam int unsigned SRAM_ADDR_WIDTH = 8;
    localparam int unsigned SRAM_NUM_WMASKS = 4;
    localparam int unsigned SRAM_DEPTH      = 1 << SRAM_ADDR_WIDTH;
    // Byte address to word address shift (4 bytes per word).
    localparam int unsigned BYTE_SHIFT      = 2;

    // Byte offset of an address inside the SRAM window.
    function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return addr - base;
    endfunction

    // An offset is in range when it falls below 4 * depth bytes; the word
    // index is then offset[aw+1:2].
    function automatic logic offset_in_range(input logic [31:0] off,
                                             input int unsigned aw);
        return (off >> (aw + BYTE_SHIFT)) == 32'd0;
    endfunction

endpackage

// File: rtl/sram_ctrl_rsp_tracker.sv
// One-deep response register for a request/grant/rvalid port: every grant
// produces exactly one rvalid on the following cycle.
module sram_ctrl_rsp_tracker #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_gnt,
    input  logic                  i_err,
    input  logic                  i_is_read,
    input  logic [DATA_WIDTH-1:0] i_dout,
    output logic                  o_rvalid,
    output logic                  o_err,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic r_valid;
    logic r_err;
    logic r_is_read;

    // Capture the accepted request's response attributes for one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_is_read <= 1'b0;
        end else begin
            r_valid   <= i_gnt;
            r_err     <= i_gnt & i_err;
            r_is_read <= i_gnt & i_is_read;
        end
    end

    assign o_rvalid = r_valid;
    assign o_err    = r_err;
    // Macro output is only meaningful for a successful read; otherwise return zero.
    assign o_rdata  = (r_valid && r_is_read && !r_err) ? i_dout : '0;

endmodule

// File: rtl/sram_ctrl_1rw1r.sv
// Initiator-side controller for a 1RW+1R byte-masked SRAM macro.
// Handshake: a port's request is accepted in any cycle where req and gnt are
// both high (gnt is combinational from req); the macro pins are driven in that
// same cycle and sampled by the macro at the closing clock edge; exactly one
// rvalid (with err and rdata) follows on the next cycle. Requests need not be
// held; back-to-back acceptance every cycle is allowed.
module sram_ctrl_1rw1r
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int unsigned NUM_WMASKS = SRAM_NUM_WMASKS,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter bit          INIT_ZERO  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  d_req_i,
    output logic                  d_gnt_o,
    input  logic                  d_we_i,
    input  logic [NUM_WMASKS-1:0] d_be_i,
    input  logic [31:0]           d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_err_o,
    input  logic                  i_req_i,
    output logic                  i_gnt_o,
    input  logic [31:0]           i_addr_i,
    output logic                  i_rvalid_o,
    output logic [DATA_WIDTH-1:0] i_rdata_o,
    output logic                  i_err_o,
    output logic                  init_done_o,
    output logic                  csb0_o,
    output logic                  web0_o,
    output logic [NUM_WMASKS-1:0] wmask0_o,
    output logic [ADDR_WIDTH-1:0] addr0_o,
    output logic [DATA_WIDTH-1:0] din0_o,
    input  logic [DATA_WIDTH-1:0] dout0_i,
    output logic                  csb1_o,
    output logic [ADDR_WIDTH-1:0] addr1_o,
    input  logic [DATA_WIDTH-1:0] dout1_i
);

    localparam state_e RESET_STATE = INIT_ZERO ? ST_INIT : ST_RUN;

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_next;

    logic [31:0]           w_d_off;
    logic [31:0]           w_i_off;
    logic                  w_d_inr;
    logic                  w_i_inr;
    logic [ADDR_WIDTH-1:0] w_d_idx;
    logic [ADDR_WIDTH-1:0] w_i_idx;
    logic                  w_hazard;

    assign w_d_off  = addr_offset(d_addr_i, BASE_ADDR);
    assign w_i_off  = addr_offset(i_addr_i, BASE_ADDR);
    assign w_d_inr  = offset_in_range(w_d_off, ADDR_WIDTH);
    assign w_i_inr  = offset_in_range(w_i_off, ADDR_WIDTH);
    assign w_d_idx  = w_d_off[ADDR_WIDTH+1:2];
    assign w_i_idx  = w_i_off[ADDR_WIDTH+1:2];
    // A same-word write and read in one cycle is undefined in the macro, so the read waits.
    assign w_hazard = d_req_i && d_we_i && w_d_inr && w_i_inr && (w_d_idx == w_i_idx);

    assign init_done_o = (r_state == ST_RUN);

    // State and fill-counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RESET_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state, grants and macro pins; everything idles while reset is held.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        d_gnt_o      = 1'b0;
        i_gnt_o      = 1'b0;
        csb0_o       = 1'b1;
        web0_o       = 1'b1;
        wmask0_o     = '0;
        addr0_o      = '0;
        din0_o       = '0;
        csb1_o       = 1'b1;
        addr1_o      = '0;
        if (rst_ni) begin
            case (r_state)
                ST_INIT: begin
                    csb0_o     = 1'b0;
                    web0_o     = 1'b0;
                    wmask0_o   = '1;
                    addr0_o    = r_cnt;
                    w_cnt_next = r_cnt + ADDR_WIDTH'(1);
                    if (r_cnt == '1) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    d_gnt_o = d_req_i;
                    if (d_req_i && w_d_inr) begin
                        csb0_o   = 1'b0;
                        web0_o   = !d_we_i;
                        wmask0_o = d_we_i ? d_be_i : '0;
                        addr0_o  = w_d_idx;
                        din0_o   = d_wdata_i;
                    end
                    i_gnt_o = i_req_i && !w_hazard;
                    if (i_req_i && !w_hazard && w_i_inr) begin
                        csb1_o  = 1'b0;
                        addr1_o = w_i_idx;
                    end
                end
                default: w_state_next = RESET_STATE;
            endcase
        end
    end

    sram_ctrl_rsp_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_d_rsp (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .i_gnt     (d_gnt_o),
        .i_err     (!w_d_inr),
        .i_is_read (!d_we_i),
        .i_dout    (dout0_i),
        .o_rvalid  (d_rvalid_o),
        .o_err     (d_err_o),
        .o_rdata   (d_rdata_o)
    );

    sram_ctrl_rsp_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_i_rsp (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .i_gnt     (i_gnt_o),
        .i_err     (!w_i_inr),
        .i_is_read (1'b1),
        .i_dout    (dout1_i),
        .o_rvalid  (i_rvalid_o),
        .o_err     (i_err_o),
        .o_rdata   (i_rdata_o)
    );

endmodule

// File: tb/tb_sram_ctrl_1rw1r.sv
// Bench for sram_ctrl_1rw1r: behavioural macro, directed vector table,
// randomized traffic against a word-array reference, and reset corner cases.
module tb_sram_ctrl_1rw1r;

    localparam logic [31:0] TB_BASE  = 32'h0000_0000;
    localparam int          TB_DEPTH = 256;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_ni;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT ----------------
    logic        d_req, d_we, i_req;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, i_addr;
    logic        d_gnt_o, d_rvalid_o, d_err_o, i_gnt_o, i_rvalid_o, i_err_o, init_done_o;
    logic [31:0] d_rdata_o, i_rdata_o;
    logic        csb0_o, web0_o, csb1_o;
    logic [3:0]  wmask0_o;
    logic [7:0]  addr0_o, addr1_o;
    logic [31:0] din0_o, dout0, dout1;

    sram_ctrl_1rw1r dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .d_req_i     (d_req),
        .d_gnt_o     (d_gnt_o),
        .d_we_i      (d_we),
        .d_be_i      (d_be),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .d_err_o     (d_err_o),
        .i_req_i     (i_req),
        .i_gnt_o     (i_gnt_o),
        .i_addr_i    (i_addr),
        .i_rvalid_o  (i_rvalid_o),
        .i_rdata_o   (i_rdata_o),
        .i_err_o     (i_err_o),
        .init_done_o (init_done_o),
        .csb0_o      (csb0_o),
        .web0_o      (web0_o),
        .wmask0_o    (wmask0_o),
        .addr0_o     (addr0_o),
        .din0_o      (din0_o),
        .dout0_i     (dout0),
        .csb1_o      (csb1_o),
        .addr1_o     (addr1_o),
        .dout1_i     (dout1)
    );

    // ---------------- behavioural macro ----------------
    // Contents are scrambled while reset is held so only the zero-fill can clear them.
    logic [31:0] mac_mem [TB_DEPTH];
    always @(posedge clk) begin
        if (!rst_ni) begin
            for (int i = 0; i < TB_DEPTH; i++) mac_mem[i] <= $urandom;
        end else begin
            if (!csb0_o) begin
                if (!web0_o) begin
                    for (int b = 0; b < 4; b++)
                        if (wmask0_o[b]) mac_mem[addr0_o][8*b +: 8] <= din0_o[8*b +: 8];
                end else begin
                    dout0 <= mac_mem[addr0_o];
                end
            end
            if (!csb1_o) dout1 <= mac_mem[addr1_o];
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] ref_mem [TB_DEPTH];
    logic [32:0] d_exp_q[$];
    logic [32:0] i_exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic in_win(input logic [31:0] a);
        logic [31:0] off;
        off = a - TB_BASE;
        return off < 32'(4 * TB_DEPTH);
    endfunction

    function automatic int unsigned word_of(input logic [31:0] a);
        return (a - TB_BASE) / 4;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < TB_DEPTH; i++) ref_mem[i] = 32'h0;
        d_exp_q.delete();
        i_exp_q.delete();
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic dreq, input logic dwe, input logic [3:0] dbe,
                         input logic [31:0] daddr, input logic [31:0] dwdata,
                         input logic ireq, input logic [31:0] iaddr);
        d_req = dreq; d_we = dwe; d_be = dbe; d_addr = daddr; d_wdata = dwdata;
        i_req = ireq; i_addr = iaddr;
    endtask

    function automatic logic [31:0] pick_addr();
        int unsigned s;
        s = $urandom_range(0, 7);
        case (s)
            0:       return 32'($urandom_range(0, 32'h1FFF));
            1:       return 32'h3F8 + 32'($urandom_range(0, 7));
            default: return 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
        endcase
    endfunction

    // Reference for one RUN cycle: grants from the port rules, response
    // expectations from the word array, then the write takes effect.
    task automatic model_cycle();
        logic d_in, i_in, haz, e_ig;
        int unsigned di, ii;
        d_in = in_win(d_addr);
        i_in = in_win(i_addr);
        di   = word_of(d_addr);
        ii   = word_of(i_addr);
        haz  = d_req && d_we && d_in && i_in && (di == ii);
        e_ig = i_req && !haz;
        chk("m_dgnt", 32'(d_gnt_o), 32'(d_req));
        chk("m_ignt", 32'(i_gnt_o), 32'(e_ig));
        chk("m_csb0", 32'(csb0_o), 32'(!(d_req && d_in)));
        chk("m_csb1", 32'(csb1_o), 32'(!(e_ig && i_in)));
        if (d_req && d_in) begin
            chk("m_addr0", 32'(addr0_o), di);
            chk("m_web0", 32'(web0_o), 32'(!d_we));
            chk("m_wmask0", 32'(wmask0_o), d_we ? 32'(d_be) : 32'h0);
        end
        if (e_ig && i_in) chk("m_addr1", 32'(addr1_o), ii);
        if (d_req) d_exp_q.push_back({!d_in, (!d_we && d_in) ? ref_mem[di] : 32'h0});
        if (e_ig)  i_exp_q.push_back({!i_in, i_in ? ref_mem[ii] : 32'h0});
        if (d_req && d_we && d_in)
            for (int b = 0; b < 4; b++)
                if (d_be[b]) ref_mem[di][8*b +: 8] = d_wdata[8*b +: 8];
    endtask

    task automatic check_rsp();
        logic [32:0] e;
        if (d_exp_q.size() != 0) begin
            e = d_exp_q.pop_front();
            chk("d_rvalid", 32'(d_rvalid_o), 32'd1);
            chk("d_err", 32'(d_err_o), 32'(e[32]));
            chk("d_rdata", d_rdata_o, e[31:0]);
        end else begin
            chk("d_rvalid_idle", 32'(d_rvalid_o), 32'd0);
        end
        if (i_exp_q.size() != 0) begin
            e = i_exp_q.pop_front();
            chk("i_rvalid", 32'(i_rvalid_o), 32'd1);
            chk("i_err", 32'(i_err_o), 32'(e[32]));
            chk("i_rdata", i_rdata_o, e[31:0]);
        end else begin
            chk("i_rvalid_idle", 32'(i_rvalid_o), 32'd0);
        end
    endtask

    // Runs n fill cycles with both requests held high; entered just after an edge.
    task automatic init_cycles(input int n);
        drive(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 32'h0);
        for (int k = 0; k < n; k++) begin
            #1;
            chk("init_done_lo", 32'(init_done_o), 32'd0);
            chk("init_csb0", 32'(csb0_o), 32'd0);
            chk("init_web0", 32'(web0_o), 32'd0);
            chk("init_wmask0", 32'(wmask0_o), 32'hF);
            chk("init_din0", din0_o, 32'h0);
            chk("init_addr0", 32'(addr0_o), 32'(k));
            chk("init_dgnt", 32'(d_gnt_o), 32'd0);
            chk("init_ignt", 32'(i_gnt_o), 32'd0);
            chk("init_csb1", 32'(csb1_o), 32'd1);
            chk("init_drvalid", 32'(d_rvalid_o), 32'd0);
            @(posedge clk);
        end
        #1;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic dreq; logic dwe; logic [3:0] dbe; logic [31:0] daddr; logic [31:0] dwdata;
        logic ireq; logic [31:0] iaddr;
        logic e_dgnt; logic e_ignt; logic e_csb0; logic e_csb1;
        logic e_drv; logic e_derr; logic [31:0] e_drd;
        logic e_irv; logic e_ierr; logic [31:0] e_ird;
    } vec_t;
    vec_t vt [15];

    initial begin
        vt[0]  = '{1'b1,1'b1,4'b0101,32'h40,32'hAABBCCDD,1'b0,32'h0,   1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0};
        vt[1]  = '{1'b1,1'b0,4'h0,32'h40,32'h0,1'b0,32'h0,             1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h00BB00DD, 1'b0,1'b0,32'h0};
        vt[2]  = '{1'b1,1'b1,4'hF,32'h80,32'h12345678,1'b1,32'h80,     1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0};
        vt[3]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,1'b1,32'h80,             1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,32'h0,        1'b1,1'b0,32'h12345678};
        vt[4]  = '{1'b1,1'b0,4'h0,32'h400,32'h0,1'b0,32'h0,            1'b1,1'b0,1'b1,1'b1, 1'b1,1'b1,32'h0,        1'b0,1'b0,32'h0};
        vt[5]  = '{1'b1,1'b1,4'hF,32'h4,32'h11111111,1'b1,32'h0,       1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0};
        vt[6]  = '{1'b1,1'b1,4'hF,32'h8,32'h22222222,1'b1,32'h4,       1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,32'h0,        1'b1,1'b0,32'h11111111};
        vt[7]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,1'b1,32'h8,              1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,32'h0,        1'b1,1'b0,32'h22222222};
        vt[8]  = '{1'b0,1'b0,4'h0,32'h0,32'h0,1'b1,32'h1000,           1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,32'h0,        1'b1,1'b1,32'h0};
        vt[9]  = '{1'b1,1'b0,4'h0,32'h10,32'h0,1'b0,32'h0,             1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0};
        vt[10] = '{1'b1,1'b0,4'h0,32'h43,32'h0,1'b0,32'h0,             1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h00BB00DD, 1'b0,1'b0,32'h0};
        vt[11] = '{1'b1,1'b1,4'h8,32'h3FC,32'hDEADBEEF,1'b1,32'h3FC,   1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0};
        vt[12] = '{1'b0,1'b0,4'h0,32'h0,32'h0,1'b1,32'h3FF,            1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,32'h0,        1'b1,1'b0,32'hDE000000};
        vt[13] = '{1'b1,1'b1,4'hF,32'h400,32'hFFFFFFFF,1'b1,32'h0,     1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,32'h0,        1'b1,1'b0,32'h0};
        vt[14] = '{1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,32'h0,              1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0};
    end

    // ---------------- test sequence ----------------
    initial begin
        rst_ni = 1'b0;
        drive(1'b1, 1'b1, 4'hF, 32'h40, 32'h5555AAAA, 1'b1, 32'h0);
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        // Reset values
        chk("rst_csb0", 32'(csb0_o), 32'd1);
        chk("rst_csb1", 32'(csb1_o), 32'd1);
        chk("rst_web0", 32'(web0_o), 32'd1);
        chk("rst_wmask0", 32'(wmask0_o), 32'h0);
        chk("rst_addr0", 32'(addr0_o), 32'h0);
        chk("rst_addr1", 32'(addr1_o), 32'h0);
        chk("rst_din0", din0_o, 32'h0);
        chk("rst_dgnt", 32'(d_gnt_o), 32'd0);
        chk("rst_ignt", 32'(i_gnt_o), 32'd0);
        chk("rst_drvalid", 32'(d_rvalid_o), 32'd0);
        chk("rst_irvalid", 32'(i_rvalid_o), 32'd0);
        chk("rst_derr", 32'(d_err_o), 32'd0);
        chk("rst_ierr", 32'(i_err_o), 32'd0);
        chk("rst_drdata", d_rdata_o, 32'h0);
        chk("rst_irdata", i_rdata_o, 32'h0);
        chk("rst_init_done", 32'(init_done_o), 32'd0);

        // Zero-fill: 256 write cycles, then init_done
        rst_ni = 1'b1;
        init_cycles(TB_DEPTH);
        chk("init_done_hi", 32'(init_done_o), 32'd1);

        // Directed vectors
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].dreq, vt[i].dwe, vt[i].dbe, vt[i].daddr, vt[i].dwdata, vt[i].ireq, vt[i].iaddr);
            #1;
            chk($sformatf("tv%0d_dgnt", i), 32'(d_gnt_o), 32'(vt[i].e_dgnt));
            chk($sformatf("tv%0d_ignt", i), 32'(i_gnt_o), 32'(vt[i].e_ignt));
            chk($sformatf("tv%0d_csb0", i), 32'(csb0_o), 32'(vt[i].e_csb0));
            chk($sformatf("tv%0d_csb1", i), 32'(csb1_o), 32'(vt[i].e_csb1));
            model_cycle();
            @(posedge clk);
            #1;
            chk($sformatf("tv%0d_drv", i), 32'(d_rvalid_o), 32'(vt[i].e_drv));
            chk($sformatf("tv%0d_derr", i), 32'(d_err_o), 32'(vt[i].e_derr));
            chk($sformatf("tv%0d_drd", i), d_rdata_o, vt[i].e_drd);
            chk($sformatf("tv%0d_irv", i), 32'(i_rvalid_o), 32'(vt[i].e_irv));
            chk($sformatf("tv%0d_ierr", i), 32'(i_err_o), 32'(vt[i].e_ierr));
            chk($sformatf("tv%0d_ird", i), i_rdata_o, vt[i].e_ird);
            check_rsp();
        end

        // Randomized traffic against the reference
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                  pick_addr(), $urandom, $urandom_range(0, 3) != 0, pick_addr());
            #1;
            model_cycle();
            @(posedge clk);
            #1;
            check_rsp();
        end

        // Reset during RUN with a read in flight: response must be dropped
        drive(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, 32'h0);
        #1;
        chk("rr_dgnt", 32'(d_gnt_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rr_dgnt_rst", 32'(d_gnt_o), 32'd0);
        chk("rr_csb0_rst", 32'(csb0_o), 32'd1);
        chk("rr_init_done", 32'(init_done_o), 32'd0);
        @(posedge clk);
        #1;
        chk("rr_drvalid", 32'(d_rvalid_o), 32'd0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        reset_model();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Reset mid-fill at counter 100, then a full restart from word 0
        init_cycles(100);
        chk("ri_addr0_100", 32'(addr0_o), 32'd100);
        rst_ni = 1'b0;
        #1;
        chk("ri_csb0_rst", 32'(csb0_o), 32'd1);
        chk("ri_addr0_rst", 32'(addr0_o), 32'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        init_cycles(TB_DEPTH);
        chk("ri_init_done", 32'(init_done_o), 32'd1);

        // Previously written words read back as zero after the new fill
        drive(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 32'h3FC);
        #1;
        model_cycle();
        @(posedge clk);
        #1;
        check_rsp();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        model_cycle();
        @(posedge clk);
        #1;
        check_rsp();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
